// File: rtl/gl_stream_pkg.sv
// Shared stream definitions for the 2x2 downscaler stages: FSM state, side-band flags, pair averaging.
// Data width is carried by each stage; the averaging helper works on a fixed wide container.
package gl_stream_pkg;

    // Widest pixel any stage may use; callers zero-extend into this and truncate the result back.
    localparam int GL_MAX_W = 16;

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } gl_state_e;

    typedef struct packed {
        logic tlast;
        logic tuser;
    } gl_side_t;

    // Sum carries one extra bit, so an all-ones pair stays all-ones instead of wrapping.
    function automatic logic [GL_MAX_W-1:0] avg2(
        input logic [GL_MAX_W-1:0] a,
        input logic [GL_MAX_W-1:0] b,
        input logic                rnd
    );
        logic [GL_MAX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[GL_MAX_W:1] + {{(GL_MAX_W-1){1'b0}}, rnd & sum[0]};
    endfunction

endpackage

// File: rtl/gl_out_reg.sv
// One-entry registered output buffer with valid/ready; reusable by any stream stage.
// Latency 1 cycle from load; upstream ready = !valid | downstream ready, data held while stalled.
module gl_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_vld,
    input  logic [W-1:0] load_dat,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         in_rdy
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    // A load can only arrive when in_rdy was high, so it never overwrites a stalled beat.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_vld) begin
            vld_d = 1'b1;
            dat_d = load_dat;
        end else if (vld_q && out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;
    assign in_rdy  = !vld_q || out_rdy;

endmodule

// File: rtl/gl2_hpair_avg.sv
// Horizontal pair averager: merges adjacent pixels of each line into one, halving line width.
// Latency 1 cycle after the odd (or lone end-of-line) pixel; up_ready follows the one-entry output buffer.
module gl2_hpair_avg
    import gl_stream_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int ROUND   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready,
    output logic               err_resync
);

    typedef struct packed {
        logic [D_WIDTH-1:0] data;
        gl_side_t           side;
    } beat_t;

    gl_state_e          state_q, state_d;
    logic [D_WIDTH-1:0] hold_q, hold_d;
    logic               hold_tuser_q, hold_tuser_d;
    logic               err_resync_q, err_resync_d;
    logic               accept;
    logic               produce;
    logic [D_WIDTH-1:0] pair_avg;
    beat_t              beat_d;
    beat_t              beat_q;

    assign accept   = up_valid && up_ready;
    assign pair_avg = D_WIDTH'(avg2(GL_MAX_W'(hold_q), GL_MAX_W'(up_data), ROUND != 0));

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_tuser_d = hold_tuser_q;
        err_resync_d = 1'b0;
        produce      = 1'b0;
        beat_d       = '0;
        if (accept) begin
            if (state_q == ST_ODD && !up_tuser) begin
                produce           = 1'b1;
                beat_d.data       = pair_avg;
                beat_d.side.tuser = hold_tuser_q;
                beat_d.side.tlast = up_tlast;
                state_d           = ST_EVEN;
            end else begin
                // A SOF landing on the odd slot abandons the half pair and restarts as an even beat.
                err_resync_d = (state_q == ST_ODD);
                if (up_tlast) begin
                    produce           = 1'b1;
                    beat_d.data       = up_data;
                    beat_d.side.tuser = up_tuser;
                    beat_d.side.tlast = 1'b1;
                    state_d           = ST_EVEN;
                end else begin
                    hold_d       = up_data;
                    hold_tuser_d = up_tuser;
                    state_d      = ST_ODD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EVEN;
            hold_q       <= '0;
            hold_tuser_q <= 1'b0;
            err_resync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_tuser_q <= hold_tuser_d;
            err_resync_q <= err_resync_d;
        end
    end

    gl_out_reg #(
        .W($bits(beat_t))
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (produce),
        .load_dat (beat_d),
        .out_rdy  (down_ready),
        .out_vld  (down_valid),
        .out_dat  (beat_q),
        .in_rdy   (up_ready)
    );

    assign down_data  = beat_q.data;
    assign down_tlast = beat_q.side.tlast;
    assign down_tuser = beat_q.side.tuser;
    assign err_resync = err_resync_q;

endmodule

// File: tb/tb_gl2_hpair_avg.sv
// Scoreboard bench for gl2_hpair_avg: ROUND=1 and ROUND=0 instances share one stimulus stream.
module tb_gl2_hpair_avg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] up_data;
    logic       up_valid, up_tlast, up_tuser;
    logic       up_ready, up_ready0;
    logic [7:0] down_data, down_data0;
    logic       down_valid, down_valid0;
    logic       down_tlast, down_tlast0;
    logic       down_tuser, down_tuser0;
    logic       down_ready;
    logic       err_resync, err0;

    logic fix_rdy = 1'b1;
    logic rnd_rdy = 1'b1;
    bit   rand_ready = 1'b0;
    assign down_ready = rand_ready ? rnd_rdy : fix_rdy;

    always #5 clk = ~clk;

    gl2_hpair_avg #(.D_WIDTH(8), .ROUND(1)) u_r1 (
        .clk(clk), .rst_n(rst_n),
        .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
        .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
        .down_tuser(down_tuser), .down_ready(down_ready), .err_resync(err_resync)
    );

    gl2_hpair_avg #(.D_WIDTH(8), .ROUND(0)) u_r0 (
        .clk(clk), .rst_n(rst_n),
        .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
        .up_ready(up_ready0),
        .down_data(down_data0), .down_valid(down_valid0), .down_tlast(down_tlast0),
        .down_tuser(down_tuser0), .down_ready(down_ready), .err_resync(err0)
    );

    typedef struct {
        int d1;
        int d0;
        bit tl;
        bit tu;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t got_q[$];
    int   cur[$];
    bit   cur_tu;
    int   vecs = 0;
    int   miscmp = 0;
    int   cyc = 0;
    bit   in_reset = 1'b1;
    bit   err_exp_prev = 1'b0;
    int   err_seen = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) rnd_rdy = ($urandom % 3) != 0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input int act);
        vecs++;
        miscmp++;
        $display("FAIL %s: got %0d (t=%0t)", nm, act, $time);
    endtask

    // Reference: collect pixels of the current pair; emit on a pair or on a lone end-of-line pixel.
    task automatic model_beat(input int d, input bit tl, input bit tu, output bit err);
        exp_t e;
        err = 1'b0;
        if (tu && cur.size() != 0) begin
            err = 1'b1;
            cur.delete();
        end
        if (cur.size() == 0) cur_tu = tu;
        cur.push_back(d);
        e.cyc = cyc + 1;
        if (cur.size() == 2) begin
            e.d1 = (cur[0] + cur[1] + 1) / 2;
            e.d0 = (cur[0] + cur[1]) / 2;
            e.tl = tl;
            e.tu = cur_tu;
            exp_q.push_back(e);
            cur.delete();
        end else if (tl) begin
            e.d1 = d;
            e.d0 = d;
            e.tl = 1'b1;
            e.tu = tu;
            exp_q.push_back(e);
            cur.delete();
        end
    endtask

    // Input side: record accepted beats into the model and check the resync flag.
    always @(negedge clk) begin
        bit e;
        if (in_reset) begin
            err_exp_prev = 1'b0;
        end else begin
            chk("err_resync", int'(err_resync), int'(err_exp_prev));
            chk("err_resync_r0", int'(err0), int'(err_exp_prev));
            if (err_resync) err_seen++;
            e = 1'b0;
            if (up_valid && up_ready) model_beat(int'(up_data), up_tlast, up_tuser, e);
            err_exp_prev = e;
        end
    end

    // Output side: pop and compare on every transfer, checking latency and stall stability.
    bit       pv = 1'b0;
    bit       pr = 1'b0;
    logic [7:0] pd = 8'd0;
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (in_reset) begin
            pv = 1'b0;
        end else begin
            if (down_valid) begin
                if (pv && !pr) chk("hold_stable", int'(down_data), int'(pd));
                else if (exp_q.size() != 0) chk("latency", cyc, exp_q[0].cyc);
                if (down_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat", int'(down_data));
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_r1", int'(down_data), e.d1);
                        chk("data_r0", int'(down_data0), e.d0);
                        chk("tlast", int'(down_tlast), int'(e.tl));
                        chk("tuser", int'(down_tuser), int'(e.tu));
                        chk("valid_r0", int'(down_valid0), 1);
                        chk("tlast_r0", int'(down_tlast0), int'(e.tl));
                    end
                    g.d1  = int'(down_data);
                    g.d0  = int'(down_data0);
                    g.tl  = down_tlast;
                    g.tu  = down_tuser;
                    g.cyc = cyc;
                    got_q.push_back(g);
                end
            end
            pv = down_valid;
            pr = down_ready;
            pd = down_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input bit tl, input bit tu);
        int n;
        bit acc;
        n = 0;
        up_data  = 8'(d);
        up_tlast = tl;
        up_tuser = tu;
        up_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = up_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 300) begin
                fail_now("send_timeout", d);
                break;
            end
        end
        up_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size());
        idle(2);
    endtask

    task automatic expect_got(input int idx, input int d1, input int d0, input bit tl, input bit tu);
        if (idx >= got_q.size()) begin
            fail_now("missing_output", idx);
        end else begin
            chk("dir_data_r1", got_q[idx].d1, d1);
            chk("dir_data_r0", got_q[idx].d0, d0);
            chk("dir_tlast", int'(got_q[idx].tl), int'(tl));
            chk("dir_tuser", int'(got_q[idx].tu), int'(tu));
        end
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_valid"}, int'(down_valid), 0);
        chk({nm, "_valid_r0"}, int'(down_valid0), 0);
        chk({nm, "_data"}, int'(down_data), 0);
        chk({nm, "_tlast"}, int'(down_tlast), 0);
        chk({nm, "_tuser"}, int'(down_tuser), 0);
        chk({nm, "_err"}, int'(err_resync), 0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        cur.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscmp);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        up_valid = 1'b0;
        up_data  = 8'd0;
        up_tlast = 1'b0;
        up_tuser = 1'b0;
        #12;
        check_cleared("reset");
        chk("reset_up_ready", int'(up_ready), 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;

        // Full line, back-to-back with down_ready high.
        got_q.delete();
        send(10, 0, 1); send(20, 0, 0); send(30, 0, 0);
        send(41, 0, 0); send(255, 0, 0); send(255, 1, 0);
        drain();
        chk("line1_count", got_q.size(), 3);
        expect_got(0, 15, 15, 0, 1);
        expect_got(1, 36, 35, 0, 0);
        expect_got(2, 255, 255, 1, 0);

        // Rounding versus truncation.
        got_q.delete();
        send(3, 0, 1); send(4, 0, 0); send(0, 0, 0); send(1, 1, 0);
        drain();
        expect_got(0, 4, 3, 0, 1);
        expect_got(1, 1, 0, 1, 0);

        // Odd-width line, then a fresh line.
        got_q.delete();
        send(8, 0, 1); send(12, 0, 0); send(100, 1, 0);
        send(6, 0, 1); send(9, 1, 0);
        drain();
        chk("odd_count", got_q.size(), 3);
        expect_got(0, 10, 10, 0, 1);
        expect_got(1, 100, 100, 1, 0);
        expect_got(2, 8, 7, 1, 1);

        // SOF on the odd slot.
        got_q.delete();
        err_seen = 0;
        send(50, 0, 0); send(60, 0, 1); send(70, 1, 0);
        drain();
        chk("resync_count", got_q.size(), 1);
        chk("resync_pulses", err_seen, 1);
        expect_got(0, 65, 65, 1, 1);

        // Downstream stall with an output pending.
        got_q.delete();
        fix_rdy = 1'b0;
        send(90, 0, 1); send(110, 1, 0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_up_ready", int'(up_ready), 0);
            chk("stall_valid", int'(down_valid), 1);
            chk("stall_data", int'(down_data), 100);
        end
        @(posedge clk);
        #1 fix_rdy = 1'b1;
        drain();
        chk("stall_count", got_q.size(), 1);
        expect_got(0, 100, 100, 1, 1);

        // Random ready/valid over a 64x4 frame, then short lines with stray SOFs.
        rand_ready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 64; p++) begin
                if ($urandom % 4 == 0) idle(1);
                send(int'($urandom % 256), p == 63, (l == 0) && (p == 0));
            end
        end
        for (int l = 0; l < 30; l++) begin
            int w;
            w = int'($urandom_range(1, 7));
            for (int p = 0; p < w; p++) begin
                if ($urandom % 4 == 0) idle(1);
                send(int'($urandom % 256), p == w - 1, ($urandom % 5) == 0);
            end
        end
        rand_ready = 1'b0;
        fix_rdy = 1'b1;
        drain();

        // Asynchronous reset while an output is stalled.
        fix_rdy = 1'b0;
        send(90, 0, 1); send(110, 0, 0);
        idle(1);
        #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        check_cleared("arst_stall");
        flush_model();
        fix_rdy = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;

        // Asynchronous reset while half a pair is held.
        send(77, 0, 1);
        #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        check_cleared("arst_odd");
        flush_model();
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;
        got_q.delete();
        send(2, 0, 1); send(6, 1, 0);
        drain();
        chk("post_reset_count", got_q.size(), 1);
        expect_got(0, 4, 4, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
